// File: rtl/mem_bist.sv
// Write-then-read-back self-test sequencer for a single-port RAM.
// Reports pass/fail, a saturating error count and the first failing word.
module mem_bist #(
   parameter int ADDR_WIDTH   = 13,
   parameter int DATA_WIDTH   = 64,
   parameter int LAST_ADDR    = 8191,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [1:0]            pattern_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count,
   output logic [ADDR_WIDTH-1:0] first_err_addr,
   output logic [DATA_WIDTH-1:0] first_err_data,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_wren,
   input  logic [DATA_WIDTH-1:0] mem_q
);

   typedef enum logic [2:0] {
      IDLE, WRITE, READ, DRAIN, DONE
   } state_t;

   function automatic logic [DATA_WIDTH-1:0] pat_f(
      input logic [1:0]            s,
      input logic [ADDR_WIDTH-1:0] a
   );
      logic [DATA_WIDTH-1:0] r;
      r = '0;
      unique case (s)
         2'd0: r = '0;
         2'd1: r = '1;
         2'd2: r = a[0] ? {(DATA_WIDTH/2){2'b01}}
                        : {(DATA_WIDTH/2){2'b10}};
         2'd3: r = DATA_WIDTH'(a);
      endcase
      return r;
   endfunction

   state_t                state, state_n;
   logic [ADDR_WIDTH-1:0] addr, addr_n;
   logic [1:0]            drain_cnt, drain_n;
   logic [1:0]            sel, sel_n;
   logic [15:0]           err_n;
   logic [ADDR_WIDTH-1:0] fe_addr_n;
   logic [DATA_WIDTH-1:0] fe_data_n;
   logic                  found, found_n;
   logic                  busy_n, done_n, pass_n, wren_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic                  last, accept, mis;
   logic [DATA_WIDTH-1:0] exp_d;

   // expected-address pipeline, aligned with the RAM read latency
   logic [READ_LATENCY-1:0] pv;
   logic [ADDR_WIDTH-1:0]   pa [READ_LATENCY];

   assign mem_address = addr;
   assign last  = (addr == ADDR_WIDTH'(LAST_ADDR));
   assign exp_d = pat_f(sel, pa[READ_LATENCY-1]);
   assign mis   = pv[READ_LATENCY-1] && (mem_q != exp_d);

   always_comb begin
      state_n   = state;
      addr_n    = addr;
      drain_n   = drain_cnt;
      sel_n     = sel;
      err_n     = err_count;
      fe_addr_n = first_err_addr;
      fe_data_n = first_err_data;
      found_n   = found;
      accept    = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               accept  = 1'b1;
               state_n = WRITE;
               addr_n  = '0;
               sel_n   = pattern_sel;
            end
         end
         WRITE: begin
            if (last) begin
               state_n = READ;
               addr_n  = '0;
            end else begin
               addr_n = addr + ADDR_WIDTH'(1);
            end
         end
         READ: begin
            if (last) begin
               state_n = DRAIN;
               drain_n = '0;
            end else begin
               addr_n = addr + ADDR_WIDTH'(1);
            end
         end
         DRAIN: begin
            if (drain_cnt == 2'(READ_LATENCY - 1)) begin
               state_n = DONE;
            end else begin
               drain_n = drain_cnt + 2'd1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (accept) begin
         err_n     = '0;
         fe_addr_n = '0;
         fe_data_n = '0;
         found_n   = 1'b0;
      end else if (mis) begin
         if (err_count != 16'hFFFF) err_n = err_count + 16'd1;
         if (!found) begin
            fe_addr_n = pa[READ_LATENCY-1];
            fe_data_n = mem_q;
            found_n   = 1'b1;
         end
      end

      busy_n = (state_n == WRITE) || (state_n == READ) ||
               (state_n == DRAIN);
      done_n = (state_n == DONE);
      pass_n = done_n && (err_n == 16'd0);
      wren_n = (state_n == WRITE);
      data_n = wren_n ? pat_f(sel_n, addr_n) : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         addr           <= '0;
         drain_cnt      <= '0;
         sel            <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
         first_err_data <= '0;
         found          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         mem_wren       <= 1'b0;
         mem_data       <= '0;
         pv             <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pa[i] <= '0;
      end else begin
         state          <= state_n;
         addr           <= addr_n;
         drain_cnt      <= drain_n;
         sel            <= sel_n;
         err_count      <= err_n;
         first_err_addr <= fe_addr_n;
         first_err_data <= fe_data_n;
         found          <= found_n;
         busy           <= busy_n;
         done           <= done_n;
         pass           <= pass_n;
         mem_wren       <= wren_n;
         mem_data       <= data_n;
         pv[0]          <= (state == READ);
         pa[0]          <= addr;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
         end
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
// Randomized scoreboard bench for mem_bist with read latencies 1 and 2.
// Each instance drives its own RAM model; both share stimulus and faults.
module tb_mem_bist;

   localparam int LAST = 15;

   typedef struct {
      int          p;
      int          err;
      logic [12:0] fa;
      logic [63:0] fd;
      logic        ps;
      int          blen;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  psel;
   logic [1:0]  busy, done, pass, wren;
   logic [15:0] err  [2];
   logic [12:0] fea  [2];
   logic [12:0] addr [2];
   logic [63:0] fed  [2];
   logic [63:0] data [2];
   logic [63:0] q    [2];

   logic [63:0] m0 [16];
   logic [63:0] m1 [16];
   logic [63:0] r1;
   logic [63:0] flip [16];

   exp_t sb0 [$];
   exp_t sb1 [$];
   int   bcnt [2];
   int   widx [2];
   logic dprev [2];
   int   n_pass = 0;
   int   n_tot  = 0;

   always #5 clk = ~clk;

   mem_bist #(
      .ADDR_WIDTH(13), .DATA_WIDTH(64),
      .LAST_ADDR(LAST), .READ_LATENCY(1)
   ) u0 (
      .clock(clk), .reset_n(reset_n), .start(start),
      .pattern_sel(psel), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .err_count(err[0]),
      .first_err_addr(fea[0]), .first_err_data(fed[0]),
      .mem_address(addr[0]), .mem_data(data[0]),
      .mem_wren(wren[0]), .mem_q(q[0])
   );

   mem_bist #(
      .ADDR_WIDTH(13), .DATA_WIDTH(64),
      .LAST_ADDR(LAST), .READ_LATENCY(2)
   ) u1 (
      .clock(clk), .reset_n(reset_n), .start(start),
      .pattern_sel(psel), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .err_count(err[1]),
      .first_err_addr(fea[1]), .first_err_data(fed[1]),
      .mem_address(addr[1]), .mem_data(data[1]),
      .mem_wren(wren[1]), .mem_q(q[1])
   );

   // faults are modelled as bit flips on the read path
   always @(posedge clk) begin
      if (wren[0]) m0[addr[0][3:0]] <= data[0];
      q[0] <= m0[addr[0][3:0]] ^ flip[addr[0][3:0]];
      if (wren[1]) m1[addr[1][3:0]] <= data[1];
      r1   <= m1[addr[1][3:0]] ^ flip[addr[1][3:0]];
      q[1] <= r1;
   end

   function automatic logic [63:0] patf(int p, int a);
      case (p)
         0:       return 64'd0;
         1:       return {64{1'b1}};
         2:       return (a % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA
                                      : 64'h5555_5555_5555_5555;
         default: return 64'(a);
      endcase
   endfunction

   function automatic exp_t model(int p, int rl);
      exp_t e;
      logic [63:0] w, r;
      e.p = p; e.err = 0; e.fa = '0; e.fd = '0;
      e.blen = 2 * (LAST + 1) + rl;
      for (int a = 0; a <= LAST; a++) begin
         w = patf(p, a);
         r = w ^ flip[a];
         if (r != w) begin
            if (e.err == 0) begin
               e.fa = 13'(a);
               e.fd = r;
            end
            e.err++;
         end
      end
      e.ps = (e.err == 0);
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      n_tot++;
      $display("FAIL %s: got event expected none", nm);
   endtask

   task automatic mon_step(input int k);
      exp_t e;
      int   sz;
      sz = (k == 0) ? sb0.size() : sb1.size();
      if (!reset_n) begin
         bcnt[k] = 0; widx[k] = 0; dprev[k] = 1'b0;
         return;
      end
      if (wren[k]) begin
         if (sz == 0) fail($sformatf("wr_unexp[%0d]", k));
         else begin
            e = (k == 0) ? sb0[0] : sb1[0];
            chk($sformatf("wr_addr[%0d]", k), 64'(addr[k]), 64'(widx[k]));
            chk($sformatf("wr_data[%0d]", k), data[k], patf(e.p, widx[k]));
            widx[k]++;
         end
      end
      if (busy[k]) bcnt[k]++;
      if (done[k] && !dprev[k]) begin
         if (sz == 0) fail($sformatf("done_unexp[%0d]", k));
         else begin
            if (k == 0) e = sb0.pop_front();
            else        e = sb1.pop_front();
            chk($sformatf("err_count[%0d]", k), 64'(err[k]), 64'(e.err));
            chk($sformatf("first_addr[%0d]", k), 64'(fea[k]), 64'(e.fa));
            chk($sformatf("first_data[%0d]", k), fed[k], e.fd);
            chk($sformatf("pass[%0d]", k), 64'(pass[k]), 64'(e.ps));
            chk($sformatf("busy_len[%0d]", k), 64'(bcnt[k]), 64'(e.blen));
            chk($sformatf("n_writes[%0d]", k), 64'(widx[k]), 64'(LAST + 1));
         end
         bcnt[k] = 0;
         widx[k] = 0;
      end
      dprev[k] = done[k];
   endtask

   initial begin
      bcnt[0] = 0; bcnt[1] = 0;
      widx[0] = 0; widx[1] = 0;
      dprev[0] = 1'b0; dprev[1] = 1'b0;
      forever begin
         @(negedge clk);
         mon_step(0);
         mon_step(1);
      end
   end

   task automatic clr_flips();
      for (int a = 0; a <= LAST; a++) flip[a] = '0;
   endtask

   task automatic run_start(input int p);
      psel  = 2'(p);
      start = 1'b1;
      sb0.push_back(model(p, 1));
      sb1.push_back(model(p, 2));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100; i++) begin
         if (done == 2'b11) break;
         @(negedge clk);
      end
      if (done != 2'b11) fail("done_timeout");
      @(negedge clk);
   endtask

   task automatic run(input int p);
      run_start(p);
      wait_done();
   endtask

   task automatic chk_idle(input string nm);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_wren[%0d]", nm, k), 64'(wren[k]), 64'd0);
         chk($sformatf("%s_busy[%0d]", nm, k), 64'(busy[k]), 64'd0);
         chk($sformatf("%s_done[%0d]", nm, k), 64'(done[k]), 64'd0);
         chk($sformatf("%s_err[%0d]", nm, k), 64'(err[k]), 64'd0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      psel    = 2'd0;
      clr_flips();
      for (int a = 0; a < 16; a++) begin
         m0[a] = '0;
         m1[a] = '0;
      end
      repeat (2) @(negedge clk);
      chk_idle("rst");
      chk("rst_pass", 64'(pass[0]), 64'd0);
      chk("rst_data", data[1], 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // asynchronous reset in the middle of the write phase
      run_start(0);
      for (int i = 0; i < 40; i++) begin
         if (wren[0] && addr[0] == 13'd7) break;
         @(negedge clk);
      end
      chk("reach_addr7", 64'(addr[0]), 64'd7);
      #2;
      sb0.delete();
      sb1.delete();
      reset_n = 1'b0;
      #1;
      chk_idle("midrst");
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run(0);

      run(3);

      flip[5] = 64'h1;
      run(1);
      chk("t3_first_data", fed[0], 64'hFFFF_FFFF_FFFF_FFFE);

      clr_flips();
      flip[3] = 64'h10;
      flip[9] = 64'h1 << 40;
      run(2);
      chk("t4_first_addr", 64'(fea[1]), 64'd3);

      // start and pattern change during READ are ignored
      clr_flips();
      flip[6] = 64'h1;
      run_start(2);
      repeat (18) @(negedge clk);
      start = 1'b1;
      psel  = 2'd0;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      run_start(1);
      chk("restart_done0", 64'(done[0]), 64'd0);
      chk("restart_done1", 64'(done[1]), 64'd0);
      chk("restart_busy", 64'(busy), 64'd3);
      wait_done();

      clr_flips();
      run(2);
      flip[15] = 64'h8000_0000_0000_0000;
      run(2);
      chk("t6_first_addr", 64'(fea[1]), 64'd15);

      for (int n = 0; n < 8; n++) begin
         int nf;
         clr_flips();
         nf = $urandom_range(0, 3);
         for (int f = 0; f < nf; f++)
            flip[$urandom_range(0, LAST)] ^= 64'h1 << $urandom_range(0, 63);
         run($urandom_range(0, 3));
      end

      repeat (3) @(negedge clk);
      chk("sb0_empty", 64'(sb0.size()), 64'd0);
      chk("sb1_empty", 64'(sb1.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
